fpu_op_sequencer: RTL and testbench
===================================

Name: fpu_op_sequencer

Overview:
- Two-requester controller that shares one MUL and one SUB single-precision unit.
- Accepts MUL (A*B), SUB (A-B) and FMS (A*B-C) requests.
- Arbitrates between requesters round-robin and drives the shared units' operand buses.
- Waits a fixed latency per unit, chains MUL->SUB for FMS, and returns the result over a valid/ready response channel to the owning requester.
- One operation is in flight at a time.

Parameters:
- MUL_LAT, 2, cycles from mul_a/mul_b stable to mul_o valid (1..15).
- SUB_LAT, 2, cycles from sub_a/sub_b stable to sub_o valid (1..15).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted when valid&&ready
- req0_op / req1_op  in  2  00=MUL, 01=SUB, 10=FMS, 11=reserved
- req0_a, req0_b, req0_c / req1_a, req1_b, req1_c  in  32  IEEE-754 operands (c used only by FMS)
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes result
- rsp_data  out  32  result, shared by both response channels
- mul_a, mul_b  out  32  operands to shared MUL
- mul_o  in  32  MUL result
- sub_a, sub_b  out  32  operands to shared SUB
- sub_o  in  32  SUB result
- busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0) values:
  - all outputs 0; state=IDLE; last_grant=1, so req0 wins first.
  - Reset mid-operation aborts it; the response is discarded and no rsp_valid is raised.
- Arbitration (IDLE only):
  - If exactly one reqN_valid is high, grant it.
  - If both are high, grant the requester opposite last_grant.
  - reqN_ready = (state==IDLE) && grantN, combinational from valids and last_grant.
  - ready is never high outside IDLE.
- Accept (cycle T): latch op, a, b, c and the owner id; update last_grant=owner. Next state:
  - MUL or FMS -> MUL_RUN; mul_a=a and mul_b=b are registered and valid from T+1.
  - SUB -> SUB_RUN; sub_a=a and sub_b=b are registered and valid from T+1.
  - reserved -> RESP with rsp_data=32'h7FC00000 (canonical NaN); shared units untouched.
- MUL_RUN:
  - A 4-bit down-counter is loaded with MUL_LAT-1 on entry; operand outputs are held stable.
  - At count 0, capture mul_o into the result register. Then:
    - op=MUL -> RESP.
    - op=FMS -> SUB_RUN with sub_a=captured product and sub_b=c, registered on the same edge.
- SUB_RUN:
  - Counter is loaded with SUB_LAT-1; operands held.
  - At count 0, capture sub_o into rsp_data -> RESP.
- RESP:
  - rsp<owner>_valid=1; the other rsp valid stays 0.
  - rsp_data is held stable until rsp<owner>_ready=1.
  - On handshake: valid drops next cycle and state=IDLE. No new accept occurs in the handshake cycle.
- Latency from accept edge to rspN_valid high:
  - MUL: MUL_LAT+1 cycles.
  - SUB: SUB_LAT+1 cycles.
  - FMS: MUL_LAT+SUB_LAT+1 cycles.
  - reserved: 1 cycle.
- Operand outputs keep their last values when not in use and are never driven to X.
- Requester inputs changing after accept have no effect.
- A deasserted reqN_valid in IDLE is not an error. Grant is recomputed every cycle until a handshake occurs.
- Operand contents (NaN, inf, zero) are passed through unchanged; special-case handling belongs to the MUL and SUB units.
- busy = (state != IDLE).

Test Plan:
- req0 MUL a=40000000 b=40400000, rsp0_ready=1 -> rsp0_valid at accept+3, rsp_data=40C00000; rsp1_valid stays 0.
- req1 SUB a=40A00000 b=40400000 -> rsp1_valid at accept+3, rsp_data=40000000; mul_a/mul_b unchanged.
- req0 FMS a=40000000 b=40400000 c=3F800000:
  - sub_a=40C00000 and sub_b=3F800000 appear at accept+3.
  - rsp0_valid at accept+5, rsp_data=40A00000.
- req0 and req1 both valid with MUL ops after reset -> req0 served first; req1_ready rises only after rsp0 handshake. Next contention grants req1.
- FMS with rsp0_ready held low for 4 cycles -> rsp0_valid and rsp_data stay constant, req0_ready/req1_ready stay 0, busy=1; completes on ready.
- reserved op=11 -> rsp_data=7FC00000 one cycle after accept.
- rst_n pulsed low mid-MUL_RUN -> all outputs 0 immediately, no response issued; the next request behaves normally.

Source files
------------

// File: rtl/fpu_op_sequencer.sv
`default_nettype none
// ==========================================================================
// fpu_op_sequencer: round-robin MUL/SUB/FMS sequencer over shared FP units
// Rev 1.0
// ==========================================================================
module fpu_op_sequencer #(
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned SUB_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [1:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [31:0] req0_c,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [1:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [31:0] req1_c,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [31:0] mul_o,
  output logic [31:0] sub_a,
  output logic [31:0] sub_b,
  input  logic [31:0] sub_o,
  output logic        busy
);

  localparam logic [1:0]  OP_MUL    = 2'b00;
  localparam logic [1:0]  OP_SUB    = 2'b01;
  localparam logic [1:0]  OP_FMS    = 2'b10;
  localparam logic [31:0] CANON_NAN = 32'h7FC0_0000;
  localparam logic [3:0]  MUL_CNT   = 4'(MUL_LAT - 1);
  localparam logic [3:0]  SUB_CNT   = 4'(SUB_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MUL_RUN = 2'd1,
    ST_SUB_RUN = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

  state_e      state_q;
  logic        last_grant_q;
  logic        owner_q;
  logic [1:0]  op_q;
  logic [31:0] c_q;
  logic [3:0]  cnt_q;
  logic [31:0] mul_a_q, mul_b_q, sub_a_q, sub_b_q;
  logic [31:0] rsp_data_q;
  logic        rsp0_valid_q, rsp1_valid_q;

  logic        w_idle, w_grant0, w_grant1, w_accept, w_own_ready;
  logic [1:0]  w_op;
  logic [31:0] w_a, w_b, w_c;

  // On contention the requester that was not served last wins.
  assign w_idle   = (state_q == ST_IDLE);
  assign w_grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign w_grant1 = req1_valid && (!req0_valid || !last_grant_q);
  assign w_accept = w_idle && (w_grant0 || w_grant1);

  assign w_op = w_grant1 ? req1_op : req0_op;
  assign w_a  = w_grant1 ? req1_a  : req0_a;
  assign w_b  = w_grant1 ? req1_b  : req0_b;
  assign w_c  = w_grant1 ? req1_c  : req0_c;

  assign w_own_ready = owner_q ? rsp1_ready : rsp0_ready;

  // Ready is qualified by rst_n so every output reads 0 while reset is held.
  assign req0_ready = rst_n && w_idle && w_grant0;
  assign req1_ready = rst_n && w_idle && w_grant1;

  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_data   = rsp_data_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign sub_a      = sub_a_q;
  assign sub_b      = sub_b_q;
  assign busy       = !w_idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_q         <= 2'b00;
      c_q          <= 32'd0;
      cnt_q        <= 4'd0;
      mul_a_q      <= 32'd0;
      mul_b_q      <= 32'd0;
      sub_a_q      <= 32'd0;
      sub_b_q      <= 32'd0;
      rsp_data_q   <= 32'd0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_accept) begin
            owner_q      <= w_grant1;
            last_grant_q <= w_grant1;
            op_q         <= w_op;
            c_q          <= w_c;
            if (w_op == OP_MUL || w_op == OP_FMS) begin
              mul_a_q <= w_a;
              mul_b_q <= w_b;
              cnt_q   <= MUL_CNT;
              state_q <= ST_MUL_RUN;
            end else if (w_op == OP_SUB) begin
              sub_a_q <= w_a;
              sub_b_q <= w_b;
              cnt_q   <= SUB_CNT;
              state_q <= ST_SUB_RUN;
            end else begin
              rsp_data_q   <= CANON_NAN;
              rsp0_valid_q <= !w_grant1;
              rsp1_valid_q <= w_grant1;
              state_q      <= ST_RESP;
            end
          end
        end
        ST_MUL_RUN: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q <= mul_o;
            if (op_q == OP_FMS) begin
              sub_a_q <= mul_o;
              sub_b_q <= c_q;
              cnt_q   <= SUB_CNT;
              state_q <= ST_SUB_RUN;
            end else begin
              rsp0_valid_q <= !owner_q;
              rsp1_valid_q <= owner_q;
              state_q      <= ST_RESP;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_SUB_RUN: begin
          if (cnt_q == 4'd0) begin
            rsp_data_q   <= sub_o;
            rsp0_valid_q <= !owner_q;
            rsp1_valid_q <= owner_q;
            state_q      <= ST_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        ST_RESP: begin
          if (w_own_ready) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_op_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_fpu_op_sequencer: directed + randomized bench with transaction-level model
// Rev 1.0
// ==========================================================================
module tb_fpu_op_sequencer;

  localparam int MUL_LAT = 2;
  localparam int SUB_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [1:0]  req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req0_c, req1_a, req1_b, req1_c;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp_data, mul_a, mul_b, mul_o, sub_a, sub_b, sub_o;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;
  int last_g = 1;

  fpu_op_sequencer #(.MUL_LAT(MUL_LAT), .SUB_LAT(SUB_LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b), .req0_c(req0_c),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b), .req1_c(req1_c),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data),
    .mul_a(mul_a), .mul_b(mul_b), .mul_o(mul_o),
    .sub_a(sub_a), .sub_b(sub_b), .sub_o(sub_o),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) * s2r(b));
  endfunction

  function automatic logic [31:0] fsub(input logic [31:0] a, input logic [31:0] b);
    return r2s(s2r(a) - s2r(b));
  endfunction

  function automatic logic [31:0] rnd_f();
    logic [7:0] e;
    e = 8'(100 + $urandom_range(0, 50));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Shared units: result becomes valid LAT cycles after operands settle.
  logic [31:0] mul_dl [0:15];
  logic [31:0] sub_dl [0:15];
  always @(posedge clk) begin
    mul_dl[0] <= fmul(mul_a, mul_b);
    sub_dl[0] <= fsub(sub_a, sub_b);
    for (int i = 1; i < 16; i++) begin
      mul_dl[i] <= mul_dl[i-1];
      sub_dl[i] <= sub_dl[i-1];
    end
  end
  assign mul_o = mul_dl[MUL_LAT-2];
  assign sub_o = sub_dl[SUB_LAT-2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
  endtask

  task automatic scramble_reqs();
    req0_valid = 1'($urandom); req1_valid = 1'($urandom);
    req0_op = 2'($urandom); req1_op = 2'($urandom);
    req0_a = $urandom; req0_b = $urandom; req0_c = $urandom;
    req1_a = $urandom; req1_b = $urandom; req1_c = $urandom;
  endtask

  // Called at a negedge with the DUT idle; returns the observed result.
  task automatic run_txn(input bit v0, input bit v1, input logic [1:0] op0, input logic [1:0] op1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [31:0] c0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [31:0] c1,
                         input int hold, output logic [31:0] data_o);
    int          g, lat;
    logic [1:0]  op;
    logic [31:0] a, b, c, prod, res, mul_a0, mul_b0, sub_a0, sub_b0;
    req0_valid = v0; req1_valid = v1;
    req0_op = op0; req0_a = a0; req0_b = b0; req0_c = c0;
    req1_op = op1; req1_a = a1; req1_b = b1; req1_c = c1;
    #1;
    g = (v0 && v1) ? 1 - last_g : (v0 ? 0 : 1);
    check("busy_idle", 32'(busy), 32'd0);
    check("req0_ready_grant", 32'(req0_ready), 32'(g == 0));
    check("req1_ready_grant", 32'(req1_ready), 32'(g == 1));
    op = g ? op1 : op0;
    a  = g ? a1 : a0;
    b  = g ? b1 : b0;
    c  = g ? c1 : c0;
    mul_a0 = mul_a; mul_b0 = mul_b; sub_a0 = sub_a; sub_b0 = sub_b;
    prod = fmul(a, b);
    case (op)
      2'b00:   begin res = prod;            lat = MUL_LAT + 1; end
      2'b01:   begin res = fsub(a, b);      lat = SUB_LAT + 1; end
      2'b10:   begin res = fsub(prod, c);   lat = MUL_LAT + SUB_LAT + 1; end
      default: begin res = 32'h7FC00000;    lat = 1; end
    endcase
    rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
    @(posedge clk);
    last_g = g;
    for (int k = 1; k < lat; k++) begin
      @(negedge clk); #1;
      check("rsp0_valid_early", 32'(rsp0_valid), 32'd0);
      check("rsp1_valid_early", 32'(rsp1_valid), 32'd0);
      check("busy_run", 32'(busy), 32'd1);
      check("ready_run", 32'({req0_ready, req1_ready}), 32'd0);
      if ((op == 2'b00 || op == 2'b10) && k == 1) begin
        check("mul_a_drive", mul_a, a);
        check("mul_b_drive", mul_b, b);
      end
      if (op == 2'b01 && k == 1) begin
        check("sub_a_drive", sub_a, a);
        check("sub_b_drive", sub_b, b);
        check("mul_a_untouched", mul_a, mul_a0);
        check("mul_b_untouched", mul_b, mul_b0);
      end
      if (op == 2'b10 && k == MUL_LAT + 1) begin
        check("fms_sub_a", sub_a, prod);
        check("fms_sub_b", sub_b, c);
      end
      scramble_reqs();
    end
    @(negedge clk); #1;
    check("rsp_own_valid", 32'(g ? rsp1_valid : rsp0_valid), 32'd1);
    check("rsp_other_valid", 32'(g ? rsp0_valid : rsp1_valid), 32'd0);
    check("rsp_data", rsp_data, res);
    check("ready_resp", 32'({req0_ready, req1_ready}), 32'd0);
    if (op == 2'b11) begin
      check("rsv_mul_a_untouched", mul_a, mul_a0);
      check("rsv_sub_b_untouched", sub_b, sub_b0);
      check("rsv_sub_a_untouched", sub_a, sub_a0);
    end
    data_o = rsp_data;
    scramble_reqs();
    for (int h = 0; h < hold; h++) begin
      if (g) rsp1_ready = 1'b0; else rsp0_ready = 1'b0;
      @(negedge clk); #1;
      check("hold_valid", 32'(g ? rsp1_valid : rsp0_valid), 32'd1);
      check("hold_data", rsp_data, res);
      check("hold_ready", 32'({req0_ready, req1_ready}), 32'd0);
      check("hold_busy", 32'(busy), 32'd1);
      scramble_reqs();
    end
    if (g) rsp1_ready = 1'b1; else rsp0_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    check("post_hs_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check("post_hs_busy", 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_rspv"}, 32'({rsp0_valid, rsp1_valid}), 32'd0);
    check({tag, "_ready"}, 32'({req0_ready, req1_ready}), 32'd0);
    check({tag, "_data"}, rsp_data, 32'd0);
    check({tag, "_mul_a"}, mul_a, 32'd0);
    check({tag, "_mul_b"}, mul_b, 32'd0);
    check({tag, "_sub_a"}, sub_a, 32'd0);
    check({tag, "_sub_b"}, sub_b, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  o0, o1;
    bit          v0, v1;
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_op = 2'b00; req1_op = 2'b00;
    req0_a = 0; req0_b = 0; req0_c = 0; req1_a = 0; req1_b = 0; req1_c = 0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_txn(1, 0, 2'b00, 2'b00, 32'h40000000, 32'h40400000, 0, 0, 0, 0, 0, d);
    check("tp_mul_2x3", d, 32'h40C00000);
    run_txn(0, 1, 2'b00, 2'b01, 0, 0, 0, 32'h40A00000, 32'h40400000, 0, 1, d);
    check("tp_sub_5m3", d, 32'h40000000);
    run_txn(1, 0, 2'b10, 2'b00, 32'h40000000, 32'h40400000, 32'h3F800000, 0, 0, 0, 0, d);
    check("tp_fms_2x3m1", d, 32'h40A00000);
    run_txn(1, 0, 2'b10, 2'b00, 32'h40000000, 32'h40400000, 32'h3F800000, 0, 0, 0, 4, d);
    check("tp_fms_hold", d, 32'h40A00000);
    run_txn(0, 1, 2'b00, 2'b11, 0, 0, 0, rnd_f(), rnd_f(), rnd_f(), 0, d);
    check("tp_reserved_nan", d, 32'h7FC00000);

    // Abort a MUL mid-flight with an async reset pulse.
    req0_valid = 1'b1; req0_op = 2'b00; req0_a = 32'h40000000; req0_b = 32'h40400000;
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    rst_n = 1'b1;
    last_g = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("post_reset_no_rsp", 32'({rsp0_valid, rsp1_valid}), 32'd0);
    end

    // Contention after reset: req0 first, then req1.
    run_txn(1, 1, 2'b00, 2'b00, 32'h40000000, 32'h40400000, 0, 32'h40A00000, 32'h40400000, 0, 2, d);
    check("contend_first_req0", d, 32'h40C00000);
    run_txn(1, 1, 2'b00, 2'b00, 32'h40000000, 32'h40400000, 0, 32'h40A00000, 32'h40400000, 0, 0, d);
    check("contend_second_req1", d, 32'h41700000);

    for (int t = 0; t < 60; t++) begin
      v0 = 1'($urandom); v1 = 1'($urandom);
      if (!v0 && !v1) v0 = 1'b1;
      o0 = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      o1 = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_txn(v0, v1, o0, o1, rnd_f(), rnd_f(), rnd_f(), rnd_f(), rnd_f(), rnd_f(),
              int'($urandom_range(0, 3)), d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
